// File: rtl/merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : merge_pkg
//  Description : Shared types, constants and key extraction for the merge tree.
//  Revision    : 1.0 - initial release
// ============================================================================
package merge_pkg;

    typedef enum logic [1:0] {
        MERGE    = 2'd0,
        DRAIN_A  = 2'd1,
        DRAIN_B  = 2'd2,
        FINISHED = 2'd3
    } merge_state_e;

    // Widest record any merger instance may carry; keys are extracted at this width.
    localparam int MAX_DATA_W = 512;

    localparam logic [MAX_DATA_W-1:0] TERM_KEY = '0;

    function automatic logic [MAX_DATA_W-1:0] key_of(
        input logic [MAX_DATA_W-1:0] data,
        input int                    key_w
    );
        logic [MAX_DATA_W-1:0] key;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            key[i] = (i < key_w) ? data[i] : 1'b0;
        end
        return key;
    endfunction

endpackage
`default_nettype wire

// File: rtl/merge_key_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : merge_key_cmp
//  Description : Unsigned key comparator; selects A on ties for a stable merge.
//  Revision    : 1.0 - initial release
// ============================================================================
module merge_key_cmp #(
    parameter int KEY_W   = 32,
    parameter bit DESCEND = 1'b0
) (
    input  logic [KEY_W-1:0] i_a_key,
    input  logic [KEY_W-1:0] i_b_key,
    output logic             o_sel_a
);

    generate
        if (DESCEND) begin : g_descend
            assign o_sel_a = (i_a_key >= i_b_key);
        end else begin : g_ascend
            assign o_sel_a = (i_a_key <= i_b_key);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/run_merger.sv
`default_nettype none
// ============================================================================
//  Module      : run_merger
//  Description : 2-to-1 merge of zero-terminated sorted runs with registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_merger
    import merge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int KEY_W   = 32,
    parameter bit DESCEND = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_empty,
    input  logic              i_a_last,
    output logic              o_a_pop,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_empty,
    input  logic              i_b_last,
    output logic              o_b_pop,
    input  logic              i_out_full,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_runs,
    output logic              o_done
);

    merge_state_e          r_state_q,  w_state_d;
    logic                  r_a_last_q, w_a_last_d;
    logic                  r_b_last_q, w_b_last_d;
    logic [DATA_W-1:0]     r_data_q,   w_data_d;
    logic                  r_valid_q,  w_valid_d;
    logic [CNT_W-1:0]      r_runs_q,   w_runs_d;
    logic                  r_done_q,   w_done_d;

    logic [MAX_DATA_W-1:0] w_a_key_full, w_b_key_full;
    logic [KEY_W-1:0]      w_a_key, w_b_key;
    logic                  w_a_term, w_b_term, w_sel_a, w_go;
    logic                  w_a_pop, w_b_pop;

    assign w_a_key_full = key_of(MAX_DATA_W'(i_a_data), KEY_W);
    assign w_b_key_full = key_of(MAX_DATA_W'(i_b_data), KEY_W);
    assign w_a_term     = (w_a_key_full == TERM_KEY);
    assign w_b_term     = (w_b_key_full == TERM_KEY);
    assign w_a_key      = w_a_key_full[KEY_W-1:0];
    assign w_b_key      = w_b_key_full[KEY_W-1:0];
    assign w_go         = !i_rst && !i_out_full;

    merge_key_cmp #(
        .KEY_W   (KEY_W),
        .DESCEND (DESCEND)
    ) u_cmp (
        .i_a_key (w_a_key),
        .i_b_key (w_b_key),
        .o_sel_a (w_sel_a)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_a_last_d = r_a_last_q;
        w_b_last_d = r_b_last_q;
        w_data_d   = r_data_q;
        w_valid_d  = 1'b0;
        w_runs_d   = r_runs_q;
        w_a_pop    = 1'b0;
        w_b_pop    = 1'b0;

        case (r_state_q)
            MERGE: begin
                if (w_go && !i_a_empty && !i_b_empty) begin
                    if (!w_a_term && !w_b_term) begin
                        w_valid_d = 1'b1;
                        if (w_sel_a) begin
                            w_a_pop  = 1'b1;
                            w_data_d = i_a_data;
                        end else begin
                            w_b_pop  = 1'b1;
                            w_data_d = i_b_data;
                        end
                    end else if (w_a_term && !w_b_term) begin
                        w_a_pop    = 1'b1;
                        w_a_last_d = i_a_last;
                        w_state_d  = DRAIN_B;
                    end else if (!w_a_term && w_b_term) begin
                        w_b_pop    = 1'b1;
                        w_b_last_d = i_b_last;
                        w_state_d  = DRAIN_A;
                    end else begin
                        w_a_pop   = 1'b1;
                        w_b_pop   = 1'b1;
                        w_valid_d = 1'b1;
                        w_data_d  = '0;
                        w_runs_d  = r_runs_q + CNT_W'(1);
                        w_state_d = (i_a_last && i_b_last) ? FINISHED : MERGE;
                    end
                end
            end
            DRAIN_B: begin
                if (w_go && !i_b_empty) begin
                    w_b_pop   = 1'b1;
                    w_valid_d = 1'b1;
                    w_data_d  = i_b_data;
                    if (w_b_term) begin
                        w_data_d = '0;
                        w_runs_d = r_runs_q + CNT_W'(1);
                        // A finished for good: B keeps draining alone until its own end
                        if (i_b_last && r_a_last_q) begin
                            w_state_d = FINISHED;
                        end else if (r_a_last_q) begin
                            w_state_d = DRAIN_B;
                        end else if (i_b_last) begin
                            w_b_last_d = 1'b1;
                            w_state_d  = DRAIN_A;
                        end else begin
                            w_state_d = MERGE;
                        end
                    end
                end
            end
            DRAIN_A: begin
                if (w_go && !i_a_empty) begin
                    w_a_pop   = 1'b1;
                    w_valid_d = 1'b1;
                    w_data_d  = i_a_data;
                    if (w_a_term) begin
                        w_data_d = '0;
                        w_runs_d = r_runs_q + CNT_W'(1);
                        if (i_a_last && r_b_last_q) begin
                            w_state_d = FINISHED;
                        end else if (r_b_last_q) begin
                            w_state_d = DRAIN_A;
                        end else if (i_a_last) begin
                            w_a_last_d = 1'b1;
                            w_state_d  = DRAIN_B;
                        end else begin
                            w_state_d = MERGE;
                        end
                    end
                end
            end
            default: begin
                w_state_d = FINISHED;
            end
        endcase

        w_done_d = (w_state_d == FINISHED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= MERGE;
            r_a_last_q <= 1'b0;
            r_b_last_q <= 1'b0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            r_runs_q   <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_last_q <= w_a_last_d;
            r_b_last_q <= w_b_last_d;
            r_data_q   <= w_data_d;
            r_valid_q  <= w_valid_d;
            r_runs_q   <= w_runs_d;
            r_done_q   <= w_done_d;
        end
    end

    assign o_a_pop = w_a_pop;
    assign o_b_pop = w_b_pop;
    assign o_data  = r_data_q;
    assign o_valid = r_valid_q;
    assign o_runs  = r_runs_q;
    assign o_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_run_merger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_merger
//  Description : Directed self-checking bench; DUT0 ascending, DUT1 descending.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_run_merger;
    import merge_pkg::*;

    localparam int DW = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic full = 1'b0;
    always #5 clk = ~clk;

    logic [DW:0]      mem_a [2][64];
    logic [DW:0]      mem_b [2][64];
    int unsigned      hd_a[2], tl_a[2], hd_b[2], tl_b[2];
    logic [DW-1:0]    a_data[2], b_data[2], data[2];
    logic             a_empty[2], a_last[2], b_empty[2], b_last[2];
    logic             a_pop[2], b_pop[2], valid[2], done[2];
    logic [15:0]      runs[2];
    logic             pa_pend[2], pb_pend[2];
    logic [DW-1:0]    olog[2][64];
    int               ocnt[2], npop[2], nboth[2];
    int               nviol = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    run_merger #(.DATA_W(DW), .KEY_W(32), .DESCEND(1'b0), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[0]), .i_a_empty(a_empty[0]), .i_a_last(a_last[0]), .o_a_pop(a_pop[0]),
        .i_b_data(b_data[0]), .i_b_empty(b_empty[0]), .i_b_last(b_last[0]), .o_b_pop(b_pop[0]),
        .i_out_full(full), .o_data(data[0]), .o_valid(valid[0]), .o_runs(runs[0]), .o_done(done[0])
    );

    run_merger #(.DATA_W(DW), .KEY_W(32), .DESCEND(1'b1), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[1]), .i_a_empty(a_empty[1]), .i_a_last(a_last[1]), .o_a_pop(a_pop[1]),
        .i_b_data(b_data[1]), .i_b_empty(b_empty[1]), .i_b_last(b_last[1]), .o_b_pop(b_pop[1]),
        .i_out_full(full), .o_data(data[1]), .o_valid(valid[1]), .o_runs(runs[1]), .o_done(done[1])
    );

    // First-word-fall-through FIFO models feeding each DUT
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            a_empty[k] = (hd_a[k] == tl_a[k]);
            b_empty[k] = (hd_b[k] == tl_b[k]);
            {a_last[k], a_data[k]} = mem_a[k][hd_a[k][5:0]];
            {b_last[k], b_data[k]} = mem_b[k][hd_b[k][5:0]];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pa_pend[k] === 1'b1) hd_a[k] <= hd_a[k] + 1;
            if (pb_pend[k] === 1'b1) hd_b[k] <= hd_b[k] + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pa_pend[k] = a_pop[k];
            pb_pend[k] = b_pop[k];
            if ((a_pop[k] && a_empty[k]) || (b_pop[k] && b_empty[k])) nviol = nviol + 1;
            npop[k] = npop[k] + int'(a_pop[k]) + int'(b_pop[k]);
            if (a_pop[k] && b_pop[k]) nboth[k] = nboth[k] + 1;
            if (valid[k] === 1'b1) begin
                olog[k][ocnt[k][5:0]] = data[k];
                ocnt[k] = ocnt[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int k, input logic [DW-1:0] d, input logic l);
        mem_a[k][tl_a[k][5:0]] = {l, d};
        tl_a[k] = tl_a[k] + 1;
    endtask

    task automatic push_b(input int k, input logic [DW-1:0] d, input logic l);
        mem_b[k][tl_b[k][5:0]] = {l, d};
        tl_b[k] = tl_b[k] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int k, input int target, input string tag);
        int cyc = 0;
        while (ocnt[k] < target && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_timeout"}, 64'(ocnt[k] >= target), 64'd1);
    endtask

    task automatic check_seq(input int k, input int start, input logic [DW-1:0] exp[8],
                             input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int idx = start + i;
            chk($sformatf("%s[%0d]", tag, i), 64'(olog[k][idx[5:0]]), 64'(exp[i]));
        end
    endtask

    initial begin
        int s;
        int p;
        int nb;

        // Reset values
        rst = 1'b1;
        step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), 64'(valid[k]), 64'd0);
            chk($sformatf("rst_data%0d", k),  64'(data[k]),  64'd0);
            chk($sformatf("rst_runs%0d", k),  64'(runs[k]),  64'd0);
            chk($sformatf("rst_done%0d", k),  64'(done[k]),  64'd0);
            chk($sformatf("rst_pops%0d", k),  64'(a_pop[k] | b_pop[k]), 64'd0);
        end
        step();
        rst = 1'b0;

        // Ascending basic merge
        s = ocnt[0]; p = npop[0];
        push_a(0, 40'd1, 0); push_a(0, 40'd4, 0); push_a(0, 40'd7, 0); push_a(0, 40'd0, 0);
        push_b(0, 40'd2, 0); push_b(0, 40'd3, 0); push_b(0, 40'd9, 0); push_b(0, 40'd0, 0);
        wait_out(0, s + 7, "asc");
        check_seq(0, s, '{40'd1, 40'd2, 40'd3, 40'd4, 40'd7, 40'd9, 40'd0, 40'd0}, 7, "asc");
        chk("asc_runs", 64'(runs[0]), 64'd1);
        chk("asc_pops", 64'(npop[0] - p), 64'd8);
        chk("asc_done", 64'(done[0]), 64'd0);

        // Tie: A's record must precede B's
        step();
        s = ocnt[0];
        push_a(0, 40'h0A_0000_0005, 0); push_a(0, 40'd0, 0);
        push_b(0, 40'h0B_0000_0005, 0); push_b(0, 40'd0, 0);
        wait_out(0, s + 3, "tie");
        check_seq(0, s, '{40'h0A_0000_0005, 40'h0B_0000_0005, 40'd0, 40'd0,
                          40'd0, 40'd0, 40'd0, 40'd0}, 3, "tie");
        chk("tie_runs", 64'(runs[0]), 64'd2);

        // Back-pressure for 3 cycles mid-run
        step();
        s = ocnt[0];
        push_a(0, 40'd10, 0); push_a(0, 40'd30, 0); push_a(0, 40'd50, 0); push_a(0, 40'd0, 0);
        push_b(0, 40'd20, 0); push_b(0, 40'd40, 0); push_b(0, 40'd60, 0); push_b(0, 40'd0, 0);
        step();
        step();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_nopop%0d", i), 64'(a_pop[0] | b_pop[0]), 64'd0);
            if (i >= 1) chk($sformatf("bp_novalid%0d", i), 64'(valid[0]), 64'd0);
            step();
        end
        full = 1'b0;
        wait_out(0, s + 7, "bp");
        check_seq(0, s, '{40'd10, 40'd20, 40'd30, 40'd40, 40'd50, 40'd60, 40'd0, 40'd0}, 7, "bp");
        chk("bp_runs", 64'(runs[0]), 64'd3);

        // Both runs empty: terminators popped together
        step();
        s = ocnt[0]; nb = nboth[0];
        push_a(0, 40'd0, 0);
        push_b(0, 40'd0, 0);
        wait_out(0, s + 1, "empty");
        chk("empty_word", 64'(olog[0][s[5:0]]), 64'd0);
        chk("empty_both_pop", 64'(nboth[0] - nb), 64'd1);
        chk("empty_runs", 64'(runs[0]), 64'd4);

        // Empty A run against non-empty B run
        step();
        s = ocnt[0];
        push_a(0, 40'd0, 0);
        push_b(0, 40'd5, 0); push_b(0, 40'd0, 0);
        wait_out(0, s + 2, "emptya");
        check_seq(0, s, '{40'd5, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0}, 2, "emptya");
        chk("emptya_runs", 64'(runs[0]), 64'd5);

        // Reset while draining B
        step();
        push_a(0, 40'd0, 0);
        push_b(0, 40'd7, 0); push_b(0, 40'd8, 0); push_b(0, 40'd9, 0); push_b(0, 40'd0, 0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_nopop0", 64'(a_pop[0] | b_pop[0]), 64'd0);
        chk("rst_mid_nopop1", 64'(a_pop[1] | b_pop[1]), 64'd0);
        step();
        rst = 1'b0;
        chk("rst_mid_state", 64'(dut0.r_state_q), 64'(MERGE));
        chk("rst_mid_runs",  64'(runs[0]),  64'd0);
        chk("rst_mid_valid", 64'(valid[0]), 64'd0);
        chk("rst_mid_data",  64'(data[0]),  64'd0);
        s = ocnt[0];
        push_a(0, 40'd0, 0);
        wait_out(0, s + 3, "post_rst");
        check_seq(0, s, '{40'd8, 40'd9, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0}, 3, "post_rst");
        chk("post_rst_runs", 64'(runs[0]), 64'd1);

        // A's stream ends first; B drains its remaining runs alone
        step();
        s = ocnt[0];
        push_a(0, 40'd1, 0); push_a(0, 40'd0, 1);
        push_b(0, 40'd2, 0); push_b(0, 40'd0, 0); push_b(0, 40'd3, 0); push_b(0, 40'd0, 1);
        wait_out(0, s + 5, "mism");
        check_seq(0, s, '{40'd1, 40'd2, 40'd0, 40'd3, 40'd0, 40'd0, 40'd0, 40'd0}, 5, "mism");
        chk("mism_runs", 64'(runs[0]), 64'd3);
        chk("mism_done", 64'(done[0]), 64'd1);
        push_a(0, 40'd5, 0);
        push_b(0, 40'd6, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("fin0_nopop%0d", i), 64'(a_pop[0] | b_pop[0]), 64'd0);
            chk($sformatf("fin0_novalid%0d", i), 64'(valid[0]), 64'd0);
        end

        // Descending merge with stream end on both sides
        step();
        s = ocnt[1];
        push_a(1, 40'd9, 0); push_a(1, 40'd3, 0); push_a(1, 40'd0, 1);
        push_b(1, 40'd8, 0); push_b(1, 40'd0, 1);
        wait_out(1, s + 4, "desc");
        check_seq(1, s, '{40'd9, 40'd8, 40'd3, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0}, 4, "desc");
        chk("desc_runs", 64'(runs[1]), 64'd1);
        chk("desc_done", 64'(done[1]), 64'd1);
        push_b(1, 40'd4, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("fin1_nopop%0d", i), 64'(a_pop[1] | b_pop[1]), 64'd0);
            chk($sformatf("fin1_novalid%0d", i), 64'(valid[1]), 64'd0);
            chk($sformatf("fin1_done%0d", i), 64'(done[1]), 64'd1);
        end

        chk("pop_of_empty", 64'(nviol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_merger.md
# run_merger

Parametrised 2-to-1 merge unit for one node of the merge tree: consumes two streams of zero-terminated sorted runs from first-word-fall-through input FIFOs and emits one zero-terminated merged run per input run pair into the downstream FIFO. It is the successor to the fixed single-mode merger controller. It adds:
- an integrated registered datapath
- configurable word and key width
- ascending or descending order
- explicit end-of-stream handling
- a merged-run counter

## Interface
- DATA_W, 32: record width in bits.
- KEY_W, 32: sort key width; key is data[KEY_W-1:0], KEY_W ≤ DATA_W.
- DESCEND, 0: 0 = ascending merge, 1 = descending merge.
- CNT_W, 16: width of merged-run counter.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_a_data  in  DATA_W  head word of FIFO A.
- i_a_empty  in  1  FIFO A empty (head invalid).
- i_a_last  in  1  qualifies A head: this terminator ends A's stream.
- o_a_pop  out  1  pop A head this cycle (combinational).
- i_b_data, i_b_empty, i_b_last, o_b_pop: same for FIFO B.
- i_out_full  in  1  downstream FIFO full.
- o_data  out  DATA_W  output word.
- o_valid  out  1  o_data to be written this cycle.
- o_runs  out  CNT_W  number of merged runs emitted.
- o_done  out  1  both streams ended and final terminator written.

## Operation
- Terminator: word with key field == 0. Keys 0 are reserved and never appear as data.
- Pop rule: no pop when i_rst, i_out_full, or the required head is empty. A pop of a head that is empty is a protocol violation. The bench flags it.
- Order test: ascending selects A when keyA ≤ keyB; descending selects A when keyA ≥ keyB. On ties A wins, which keeps the merge stable. Keys compare unsigned.
- States (package enum): MERGE, DRAIN_A, DRAIN_B, FINISHED. Reset state is MERGE.
- MERGE requires both heads non-empty:
  - Neither head is a terminator: pop the selected side and emit its word.
  - Only A is a terminator: pop A, emit nothing, go to DRAIN_B.
  - Only B is a terminator: pop B, emit nothing, go to DRAIN_A.
  - Both are terminators: pop both, emit one terminator, increment o_runs. If i_a_last & i_b_last, go to FINISHED; otherwise stay in MERGE.
- DRAIN_B requires B non-empty; A is not popped:
  - Head is not a terminator: pop and emit it.
  - Head is a terminator: pop it, emit one terminator, increment o_runs.
  - Next state after the terminator: if B's terminator has i_b_last and the A terminator popped on entry had i_a_last (latched flag), go to FINISHED; otherwise go to MERGE.
- DRAIN_A mirrors DRAIN_B.
- Mismatched ends: if only one side's latched last flag is set, that side's stream end is kept. The other side keeps merging as if the first side had an empty run for every remaining run. Its words drain run by run; the state stays in DRAIN of the other side until the other side's last terminator, then goes to FINISHED.
- FINISHED: no pops, o_valid=0, o_done=1. It leaves only on i_rst.
- o_runs wraps modulo 2^CNT_W.

## Timing
- Pops are combinational from state, heads and i_out_full, in the same cycle.
- o_data/o_valid are registered and appear on the edge after the pop. Latency is 1 cycle.
- Throughput: 1 word per cycle when heads are available and output is not full. Absorbing a terminator costs 1 bubble cycle with no emit.
- i_out_full is sampled in the pop cycle. The downstream FIFO must reserve one slot of slack for the in-flight word.
- o_runs and o_done update on the same edge as the emitted terminator's o_valid.
- Reset values: o_valid=0, o_data=0, o_runs=0, o_done=0, state=MERGE, latched last flags=0, o_a_pop=o_b_pop=0.
- Reset mid-run clears all state on the next edge. Partial runs are not flushed, and pops are suppressed while i_rst=1.

## Structure
- Package merge_pkg holds:
  - the state enum
  - the TERM_KEY constant (0)
  - the function key_of(data)
- One sub-module, merge_key_cmp: parametrised on KEY_W and DESCEND, produces sel_a from the two keys. It is combinational and reusable by wider-radix mergers.
- The FSM, pop logic, output register and counter live in run_merger.

## Test plan
- Ascending, A=[1,4,7,0], B=[2,3,9,0], no full: output 1,2,3,4,7,9,0; o_runs=1; 8 pops total.
- Tie and stability, DATA_W=40, KEY_W=32: A head key 5 with payload 0xA, B head key 5 with payload 0xB. Output shows A's record before B's.
- DESCEND=1, A=[9,3,0](last), B=[8,0](last): output 9,8,3,0. Then o_done=1, no further pops, o_valid=0.
- Back-pressure: raise i_out_full for 3 cycles mid-run. No pops during those cycles, o_valid low one cycle later, and the sequence is unchanged after release.
- Empty run and simultaneous terminators:
  - A=[0], B=[0]: one terminator emitted; both popped in the same cycle.
  - A=[0], B=[5,0]: output 5,0.
- Reset mid-DRAIN_B: assert i_rst for 1 cycle. Next cycle state=MERGE, o_runs=0, o_valid=0, and no pops during reset.
